// File: rtl/dst_buf_pkg.sv
// Shared configuration, beat index type and drain FSM encoding for the result buffer.
package dst_buf_pkg;

   localparam int WORD_W     = 32;
   localparam int DEPTH      = 1024;
   localparam int LEN_W      = 10;
   localparam int ADDR_W     = $clog2(DEPTH);
   localparam int BANK_BEATS = DEPTH / 2;
   localparam int BEAT_W     = 2 * WORD_W;
   localparam int IDX_W      = $clog2(BANK_BEATS);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(BANK_BEATS);

   typedef logic [IDX_W-1:0] beat_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      STREAM,
      FLUSH
   } dst_state_t;

   // A request longer than a bank holds drains the whole bank.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len > LEN_MAX) ? LEN_MAX : len;
   endfunction

endpackage

// File: rtl/dst_buf_bank.sv
// One ping-pong bank: even/odd word halves, a 32-bit write port and a 64-bit synchronous read.
// With DST_BUF_CLEAR_ON_DRAIN_EN the read also zeroes the beat it returns.
module dst_buf_bank
   import dst_buf_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_wa,
   input  logic [WORD_W-1:0] i_wd,
`ifdef DST_BUF_CLEAR_ON_DRAIN_EN
   input  logic              i_clr,
`endif
   input  logic              i_re,
   input  beat_idx_t         i_ra,
   output logic [BEAT_W-1:0] o_rd
);

   logic [WORD_W-1:0] r_even [BANK_BEATS];
   logic [WORD_W-1:0] r_odd  [BANK_BEATS];

   logic              w_even_we;
   logic              w_odd_we;
   beat_idx_t         w_widx;
   logic [WORD_W-1:0] w_wd;

`ifdef DST_BUF_CLEAR_ON_DRAIN_EN
   // The clear shares the single write port of each half; core writes to a
   // bank being drained are already discarded upstream, so they never collide.
   assign w_even_we = i_clr | (i_we & ~i_wa[0]);
   assign w_odd_we  = i_clr | (i_we &  i_wa[0]);
   assign w_widx    = i_clr ? i_ra : i_wa[ADDR_W-1:1];
   assign w_wd      = i_clr ? '0   : i_wd;
`else
   assign w_even_we = i_we & ~i_wa[0];
   assign w_odd_we  = i_we &  i_wa[0];
   assign w_widx    = i_wa[ADDR_W-1:1];
   assign w_wd      = i_wd;
`endif

   // NOTE: storage arrays carry no reset so they map onto RAM macros.
   always_ff @(posedge clk) begin
      if (w_even_we) r_even[w_widx] <= w_wd;
      if (w_odd_we)  r_odd[w_widx]  <= w_wd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_rd <= '0;
      end else if (i_re) begin
         o_rd <= {r_odd[i_ra], r_even[i_ra]};
      end
   end

endmodule

// File: rtl/dst_buf.sv
// Ping-pong result buffer: cores write 32-bit words, a drain engine streams 64-bit beats to the DMA.
// Optional DST_BUF_CLEAR_ON_DRAIN_EN makes the drain zero the bank it reads.
module dst_buf
   import dst_buf_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              exec_dst_v,
   input  logic [ADDR_W:0]   exec_dst_a,
   input  logic [WORD_W-1:0] exec_dst_d,
   input  logic              drain_start,
   input  logic              drain_bank,
   input  logic [LEN_W-1:0]  drain_len,
   output logic              dst_valid,
   output logic [BEAT_W-1:0] dst_data,
   output logic              dst_last,
   input  logic              dst_ready,
   output logic              busy,
   output logic              done
);

   dst_state_t        r_state;
   logic              r_bank;
   beat_idx_t         r_last_idx;
   beat_idx_t         r_rd_idx;
   logic              r_busy;
   logic              r_done;

   // Pipeline: bank read register (r_rv) ahead of a one-entry skid (r_sv).
   logic              r_rv;
   logic              r_rlast;
   logic              r_sv;
   logic              r_slast;
   logic [BEAT_W-1:0] r_skid;

   logic [LEN_W-1:0]  w_len;
   logic              w_issue;
   logic              w_issue_last;
   logic              w_ram_taken;
   logic              w_move;
   logic              w_fire;
   logic [BEAT_W-1:0] w_rd0;
   logic [BEAT_W-1:0] w_rd1;
   logic [BEAT_W-1:0] w_ram_beat;
   logic              w_we0;
   logic              w_we1;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_len        = clamp_len(drain_len);
      w_issue      = 1'b0;
      w_issue_last = 1'b0;
      if ((r_state == FETCH) || (r_state == STREAM)) begin
         w_issue      = ~r_sv | dst_ready;
         w_issue_last = w_issue & (r_rd_idx == r_last_idx);
      end
   end

   assign w_ram_beat  = r_bank ? w_rd1 : w_rd0;
   assign w_ram_taken = r_rv & ~r_sv & dst_ready;
   assign w_move      = w_issue & r_rv & ~w_ram_taken;

   assign dst_valid = r_sv | r_rv;
   assign dst_data  = r_sv ? r_skid  : (r_rv ? w_ram_beat : '0);
   assign dst_last  = r_sv ? r_slast : (r_rv & r_rlast);
   assign w_fire    = dst_valid & dst_ready;
   assign busy      = r_busy;
   assign done      = r_done;

   // Writes into the bank being drained are dropped; the other bank stays open.
   assign w_we0 = exec_dst_v & ~exec_dst_a[ADDR_W] & ~(r_busy & ~r_bank);
   assign w_we1 = exec_dst_v &  exec_dst_a[ADDR_W] & ~(r_busy &  r_bank);

   // NOTE: sequential state uses non-blocking assignments; a later assignment
   // in the same block overrides an earlier default.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_bank     <= 1'b0;
         r_last_idx <= '0;
         r_rd_idx   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (drain_start) begin
                  r_bank <= drain_bank;
                  if (w_len == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state    <= FETCH;
                     r_busy     <= 1'b1;
                     r_rd_idx   <= '0;
                     r_last_idx <= beat_idx_t'(w_len - LEN_W'(1));
                  end
               end
            end
            FETCH, STREAM: begin
               if (w_issue) begin
                  r_rd_idx <= r_rd_idx + beat_idx_t'(1);
                  r_state  <= w_issue_last ? FLUSH : STREAM;
               end
            end
            FLUSH: begin
               if (w_fire && dst_last) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rv    <= 1'b0;
         r_rlast <= 1'b0;
         r_sv    <= 1'b0;
         r_slast <= 1'b0;
         r_skid  <= '0;
      end else begin
         r_rv <= w_issue | (r_rv & ~w_ram_taken);
         r_sv <= (r_sv & ~dst_ready) | w_move;
         if (w_issue) r_rlast <= w_issue_last;
         // A fresh read would overwrite an unaccepted beat, so park it in the skid.
         if (w_move) begin
            r_skid  <= w_ram_beat;
            r_slast <= r_rlast;
         end
      end
   end

   dst_buf_bank u_bank0 (
      .clk  (clk),
      .rst  (rst),
      .i_we (w_we0),
      .i_wa (exec_dst_a[ADDR_W-1:0]),
      .i_wd (exec_dst_d),
`ifdef DST_BUF_CLEAR_ON_DRAIN_EN
      .i_clr(w_issue & ~r_bank),
`endif
      .i_re (w_issue & ~r_bank),
      .i_ra (r_rd_idx),
      .o_rd (w_rd0)
   );

   dst_buf_bank u_bank1 (
      .clk  (clk),
      .rst  (rst),
      .i_we (w_we1),
      .i_wa (exec_dst_a[ADDR_W-1:0]),
      .i_wd (exec_dst_d),
`ifdef DST_BUF_CLEAR_ON_DRAIN_EN
      .i_clr(w_issue & r_bank),
`endif
      .i_re (w_issue & r_bank),
      .i_ra (r_rd_idx),
      .o_rd (w_rd1)
   );

endmodule

// File: tb/tb_dst_buf.sv
// Self-checking bench for dst_buf against a word-array model of both banks.
module tb_dst_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        exec_dst_v;
   logic [10:0] exec_dst_a;
   logic [31:0] exec_dst_d;
   logic        drain_start;
   logic        drain_bank;
   logic [9:0]  drain_len;
   logic        dst_valid;
   logic [63:0] dst_data;
   logic        dst_last;
   logic        dst_ready;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_mem [2][1024];

   dst_buf dut (
      .clk        (clk),
      .rst        (rst),
      .exec_dst_v (exec_dst_v),
      .exec_dst_a (exec_dst_a),
      .exec_dst_d (exec_dst_d),
      .drain_start(drain_start),
      .drain_bank (drain_bank),
      .drain_len  (drain_len),
      .dst_valid  (dst_valid),
      .dst_data   (dst_data),
      .dst_last   (dst_last),
      .dst_ready  (dst_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic wr(input logic b, input int a, input logic [31:0] d);
      @(negedge clk);
      exec_dst_v = 1'b1;
      exec_dst_a = {b, a[9:0]};
      exec_dst_d = d;
      m_mem[b][a] = d;
      @(negedge clk);
      exec_dst_v = 1'b0;
   endtask

   task automatic idle_quiet(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         checks++;
         if (dst_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: valid=%b done=%b busy=%b want 0/0/0", tag, dst_valid, done, busy);
         end
      end
   endtask

   // Expected beats come from the word model; rmode 0 = ready high, 1 = 1,0,0 pattern, 2 = random.
   task automatic run_drain(input string tag, input logic b, input logic [9:0] len,
                            input int rmode, input bit b2b, input bit side_ops);
      logic [63:0] exp_q[$];
      logic [63:0] prev_d;
      logic        prev_l;
      bit          prev_stall;
      bit          seen_done;
      bit          exp_done;
      bit          exp_busy;
      bit          rdy;
      int          n;
      int          hs;
      int          cyc;
      int          last_hs_cyc;

      n = (len > 10'd512) ? 512 : int'(len);
      for (int k = 0; k < n; k++) exp_q.push_back({m_mem[b][2*k+1], m_mem[b][2*k]});
`ifdef DST_BUF_CLEAR_ON_DRAIN_EN
      for (int k = 0; k < n; k++) begin
         m_mem[b][2*k]   = '0;
         m_mem[b][2*k+1] = '0;
      end
`endif
      if (!b2b) @(negedge clk);
      drain_start = 1'b1;
      drain_bank  = b;
      drain_len   = len;
      dst_ready   = 1'b1;
      hs = 0; cyc = 0; last_hs_cyc = -10;
      seen_done = 0; prev_stall = 0; prev_d = '0; prev_l = 1'b0;

      while (!seen_done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         drain_start = 1'b0;
         if (side_ops && cyc == 5) exec_dst_v = 1'b0;

         exp_done = (n == 0) ? (cyc == 1) : (hs == n && cyc == last_hs_cyc + 1);
         exp_busy = (n != 0) && (hs < n);
         checks++;
         if (done !== exp_done) begin
            errors++;
            $display("FAIL %s done cyc %0d: got %b want %b", tag, cyc, done, exp_done);
         end
         checks++;
         if (busy !== exp_busy) begin
            errors++;
            $display("FAIL %s busy cyc %0d: got %b want %b", tag, cyc, busy, exp_busy);
         end
         if (rmode == 0 || hs >= n) begin
            checks++;
            if (dst_valid !== (n > 0 && cyc >= 2 && hs < n)) begin
               errors++;
               $display("FAIL %s valid cyc %0d: got %b want %b", tag, cyc, dst_valid,
                        (n > 0 && cyc >= 2 && hs < n));
            end
         end
         if (prev_stall) begin
            checks++;
            if (dst_valid !== 1'b1 || dst_data !== prev_d || dst_last !== prev_l) begin
               errors++;
               $display("FAIL %s stall hold cyc %0d: got %b/%h/%b want 1/%h/%b", tag, cyc,
                        dst_valid, dst_data, dst_last, prev_d, prev_l);
            end
         end
         if (dst_valid === 1'b1 && hs < n) begin
            checks++;
            if (dst_data !== exp_q[hs] || dst_last !== (hs == n - 1)) begin
               errors++;
               $display("FAIL %s beat %0d: got %h last %b want %h last %b", tag, hs,
                        dst_data, dst_last, exp_q[hs], (hs == n - 1));
            end
         end
         if (done === 1'b1) seen_done = 1;

         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 2);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         dst_ready  = rdy;
         prev_stall = (dst_valid === 1'b1) && !rdy;
         prev_d     = dst_data;
         prev_l     = dst_last;
         if (dst_valid === 1'b1 && rdy) begin
            hs++;
            last_hs_cyc = cyc;
         end

         if (side_ops && cyc == 3) begin
            exec_dst_v  = 1'b1;
            exec_dst_a  = {1'b1, 10'd0};
            exec_dst_d  = 32'h0000_DEAD;
            if (b != 1'b1) m_mem[1][0] = 32'h0000_DEAD;
            drain_start = 1'b1;
            drain_bank  = ~b;
            drain_len   = 10'd5;
         end
         if (side_ops && cyc == 4) begin
            exec_dst_a = {1'b0, 10'd0};
            exec_dst_d = 32'h0000_BEEF;
            if (b != 1'b0) m_mem[0][0] = 32'h0000_BEEF;
         end
      end

      checks++;
      if (!seen_done || hs != n) begin
         errors++;
         $display("FAIL %s completion: done_seen=%0d handshakes=%0d want 1/%0d", tag, seen_done, hs, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      exec_dst_v = 1'b0; exec_dst_a = '0; exec_dst_d = '0;
      drain_start = 1'b0; drain_bank = 1'b0; drain_len = '0; dst_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (dst_valid !== 1'b0 || dst_last !== 1'b0 || dst_data !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset: valid=%b last=%b data=%h busy=%b done=%b want all 0",
                  dst_valid, dst_last, dst_data, busy, done);
      end
      rst = 1'b0;
      idle_quiet("reset", 2);
   endtask

   task automatic init_mem();
      for (int bk = 0; bk < 2; bk++)
         for (int a = 0; a < 1024; a++) wr(1'(bk), a, $urandom);
   endtask

   task automatic test_basic();
      for (int i = 0; i < 8; i++) wr(1'b0, i, 32'h10 + i);
      run_drain("basic", 1'b0, 10'd4, 0, 0, 0);
   endtask

   task automatic test_stall();
      for (int i = 0; i < 8; i++) wr(1'b0, i, 32'h10 + i);
      run_drain("stall_pattern", 1'b0, 10'd4, 1, 0, 0);
      run_drain("stall_random", 1'b1, 10'd37, 2, 0, 0);
   endtask

   task automatic test_write_during_drain();
      run_drain("wr_during", 1'b1, 10'd8, 0, 0, 1);
      idle_quiet("ignored_start", 4);
      run_drain("bank1_redrain", 1'b1, 10'd8, 0, 0, 0);
      run_drain("bank0_beef", 1'b0, 10'd2, 0, 0, 0);
   endtask

   task automatic test_len_bounds();
      run_drain("len0", 1'b0, 10'd0, 0, 0, 0);
      idle_quiet("len0", 2);
      run_drain("len1", 1'b1, 10'd1, 2, 0, 0);
      run_drain("len1023", 1'b0, 10'd1023, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      run_drain("b2b_a", 1'b1, 10'd4, 0, 0, 0);
      run_drain("b2b_b", 1'b0, 10'd3, 0, 1, 0);
      run_drain("b2b_c", 1'b1, 10'd0, 0, 1, 0);
      run_drain("b2b_d", 1'b1, 10'd2, 1, 1, 0);
   endtask

   task automatic test_reset_mid_stream();
      for (int i = 0; i < 16; i++) wr(1'b0, i, $urandom);
      @(negedge clk);
      drain_start = 1'b1; drain_bank = 1'b0; drain_len = 10'd8; dst_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         drain_start = 1'b0;
      end
      checks++;
      if (dst_valid !== 1'b1 || dst_data !== {m_mem[0][5], m_mem[0][4]}) begin
         errors++;
         $display("FAIL rst_mid beat2: valid=%b data=%h want 1/%h", dst_valid, dst_data, {m_mem[0][5], m_mem[0][4]});
      end
      rst = 1'b1;
      #1;
      checks++;
      if (dst_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid abort: valid=%b busy=%b done=%b want 0/0/0", dst_valid, busy, done);
      end
      @(negedge clk);
      rst = 1'b0;
      idle_quiet("rst_mid_after", 6);
      for (int i = 0; i < 16; i++) wr(1'b0, i, $urandom);
      run_drain("rst_mid_redrain", 1'b0, 10'd8, 2, 0, 0);
   endtask

   task automatic test_repeat_drain();
      for (int i = 0; i < 8; i++) wr(1'b0, i, 32'h10 + i);
      run_drain("repeat_1", 1'b0, 10'd4, 0, 0, 0);
      run_drain("repeat_2", 1'b0, 10'd4, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      init_mem();
      test_basic();
      test_stall();
      test_write_during_drain();
      test_len_bounds();
      test_back_to_back();
      test_reset_mid_stream();
      test_repeat_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
